// File: rtl/vga_fill_pkg.sv
// Shared constants, register map, FSM states and plot-word packing for the
// rectangle-fill sequencer.
package vga_fill_pkg;

  localparam int H_RES = 160;
  localparam int V_RES = 120;
  localparam int CNT_W = 16;

  localparam logic [3:0] ADDR_CTRL   = 4'd0;
  localparam logic [3:0] ADDR_X0     = 4'd1;
  localparam logic [3:0] ADDR_Y0     = 4'd2;
  localparam logic [3:0] ADDR_X1     = 4'd3;
  localparam logic [3:0] ADDR_Y1     = 4'd4;
  localparam logic [3:0] ADDR_COLOUR = 4'd5;
  localparam logic [3:0] ADDR_COUNT  = 4'd6;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    DRAW  = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Plotter word layout: [30:24]=y, [23:16]=x, [7:0]=colour, rest zero.
  function automatic logic [31:0] pack_plot(input logic [7:0] x,
                                            input logic [6:0] y,
                                            input logic [7:0] colour);
    return {1'b0, y, x, 8'h00, colour};
  endfunction

endpackage

// File: rtl/vga_fill_regs.sv
// Host-facing register file for the fill sequencer: corner/colour storage,
// control strobes and the one-cycle-latency read data pipeline.
module vga_fill_regs #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       s_address,
  input  logic             s_read,
  output logic [31:0]      s_readdata,
  input  logic             s_write,
  input  logic [31:0]      s_writedata,
  input  logic             busy,
  input  logic             done,
  input  logic [CNT_W-1:0] count,
  output logic [7:0]       x0,
  output logic [6:0]       y0,
  output logic [7:0]       x1,
  output logic [6:0]       y1,
  output logic [7:0]       colour,
  output logic             start_req,
  output logic             abort_req
);
  import vga_fill_pkg::*;

  logic [7:0]  x0_q, x0_d;
  logic [6:0]  y0_q, y0_d;
  logic [7:0]  x1_q, x1_d;
  logic [6:0]  y1_q, y1_d;
  logic [7:0]  colour_q, colour_d;
  logic [31:0] rdata_q, rdata_d;
  logic        ctrl_wr;
  logic        unused_wdata;

  assign unused_wdata = ^s_writedata[31:8];
  assign ctrl_wr      = s_write && (s_address == ADDR_CTRL);
  // Abort dominates: a write carrying both bits never launches an operation.
  assign start_req    = ctrl_wr && s_writedata[0] && !s_writedata[1];
  assign abort_req    = ctrl_wr && s_writedata[1];

  always_comb begin
    x0_d     = x0_q;
    y0_d     = y0_q;
    x1_d     = x1_q;
    y1_d     = y1_q;
    colour_d = colour_q;
    if (s_write && !busy) begin
      case (s_address)
        ADDR_X0:     x0_d     = s_writedata[7:0];
        ADDR_Y0:     y0_d     = s_writedata[6:0];
        ADDR_X1:     x1_d     = s_writedata[7:0];
        ADDR_Y1:     y1_d     = s_writedata[6:0];
        ADDR_COLOUR: colour_d = s_writedata[7:0];
        default:     ;
      endcase
    end

    rdata_d = '0;
    if (s_read) begin
      case (s_address)
        ADDR_CTRL:   rdata_d = {30'd0, done, busy};
        ADDR_X0:     rdata_d = {24'd0, x0_q};
        ADDR_Y0:     rdata_d = {25'd0, y0_q};
        ADDR_X1:     rdata_d = {24'd0, x1_q};
        ADDR_Y1:     rdata_d = {25'd0, y1_q};
        ADDR_COLOUR: rdata_d = {24'd0, colour_q};
        ADDR_COUNT:  rdata_d = 32'(count);
        default:     rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      x0_q     <= '0;
      y0_q     <= '0;
      x1_q     <= '0;
      y1_q     <= '0;
      colour_q <= '0;
      rdata_q  <= '0;
    end else begin
      x0_q     <= x0_d;
      y0_q     <= y0_d;
      x1_q     <= x1_d;
      y1_q     <= y1_d;
      colour_q <= colour_d;
      rdata_q  <= rdata_d;
    end
  end

  assign x0         = x0_q;
  assign y0         = y0_q;
  assign x1         = x1_q;
  assign y1         = y1_q;
  assign colour     = colour_q;
  assign s_readdata = rdata_q;

endmodule

// File: rtl/vga_fill_ctrl.sv
// Rectangle-fill sequencer: normalises and clips the programmed rectangle,
// then streams one packed plot write per pixel over an Avalon-MM master.
module vga_fill_ctrl #(
  parameter int H_RES = vga_fill_pkg::H_RES,
  parameter int V_RES = vga_fill_pkg::V_RES,
  parameter int CNT_W = vga_fill_pkg::CNT_W
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  s_address,
  input  logic        s_read,
  output logic [31:0] s_readdata,
  input  logic        s_write,
  input  logic [31:0] s_writedata,
  output logic        m_write,
  output logic [31:0] m_writedata,
  input  logic        m_waitrequest
);
  import vga_fill_pkg::*;

  localparam logic [7:0] X_MAX = 8'(H_RES - 1);
  localparam logic [6:0] Y_MAX = 7'(V_RES - 1);

  state_e             state_q, state_d;
  logic [7:0]         x_q, x_d, xl_q, xl_d, xh_q, xh_d;
  logic [6:0]         y_q, y_d, yh_q, yh_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               abort_pend_q, abort_pend_d;

  logic [7:0]         x0, x1, colour;
  logic [6:0]         y0, y1;
  logic               start_req, abort_req;
  logic [7:0]         xl_n, xh_n;
  logic [6:0]         yl_n, yh_n;
  logic               off_screen;
  logic               accept;

  vga_fill_regs #(.CNT_W(CNT_W)) u_regs (
    .clk         (clk),
    .reset       (reset),
    .s_address   (s_address),
    .s_read      (s_read),
    .s_readdata  (s_readdata),
    .s_write     (s_write),
    .s_writedata (s_writedata),
    .busy        (busy_q),
    .done        (done_q),
    .count       (count_q),
    .x0          (x0),
    .y0          (y0),
    .x1          (x1),
    .y1          (y1),
    .colour      (colour),
    .start_req   (start_req),
    .abort_req   (abort_req)
  );

  // Corner normalisation and clipping; only consumed in SETUP.
  always_comb begin
    xl_n = (x0 <= x1) ? x0 : x1;
    xh_n = (x0 <= x1) ? x1 : x0;
    yl_n = (y0 <= y1) ? y0 : y1;
    yh_n = (y0 <= y1) ? y1 : y0;
    if (xh_n > X_MAX) xh_n = X_MAX;
    if (yh_n > Y_MAX) yh_n = Y_MAX;
    off_screen = (xl_n > X_MAX) || (yl_n > Y_MAX);
  end

  assign m_write     = (state_q == DRAW);
  assign m_writedata = m_write ? pack_plot(x_q, y_q, colour) : 32'd0;
  assign accept      = m_write && !m_waitrequest;

  always_comb begin
    state_d      = state_q;
    x_d          = x_q;
    y_d          = y_q;
    xl_d         = xl_q;
    xh_d         = xh_q;
    yh_d         = yh_q;
    count_d      = count_q;
    done_d       = done_q;
    abort_pend_d = abort_pend_q;

    case (state_q)
      IDLE: begin
        if (start_req) begin
          state_d      = SETUP;
          done_d       = 1'b0;
          count_d      = '0;
          abort_pend_d = 1'b0;
        end
      end
      SETUP: begin
        if (abort_req) begin
          state_d = IDLE;
        end else if (off_screen) begin
          state_d = DONE;
        end else begin
          xl_d    = xl_n;
          xh_d    = xh_n;
          yh_d    = yh_n;
          x_d     = xl_n;
          y_d     = yl_n;
          state_d = DRAW;
        end
      end
      DRAW: begin
        // A stalled beat is always completed before an abort takes effect.
        if (accept) begin
          count_d = count_q + CNT_W'(1);
          if (abort_req || abort_pend_q) begin
            state_d = IDLE;
          end else if (x_q == xh_q) begin
            if (y_q == yh_q) begin
              state_d = DONE;
            end else begin
              x_d = xl_q;
              y_d = y_q + 7'd1;
            end
          end else begin
            x_d = x_q + 8'd1;
          end
        end else if (abort_req) begin
          abort_pend_d = 1'b1;
        end
      end
      DONE: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      x_q          <= '0;
      y_q          <= '0;
      xl_q         <= '0;
      xh_q         <= '0;
      yh_q         <= '0;
      count_q      <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      abort_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      y_q          <= y_d;
      xl_q         <= xl_d;
      xh_q         <= xh_d;
      yh_q         <= yh_d;
      count_q      <= count_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      abort_pend_q <= abort_pend_d;
    end
  end

endmodule

// File: tb/tb_vga_fill_ctrl.sv
// Self-checking bench for vga_fill_ctrl: a pixel-list reference model built
// from the rectangle rules, checked beat by beat with random stalls.
module tb_vga_fill_ctrl;

  localparam int H = 160;
  localparam int V = 120;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  s_address;
  logic        s_read;
  logic [31:0] s_readdata;
  logic        s_write;
  logic [31:0] s_writedata;
  logic        m_write;
  logic [31:0] m_writedata;
  logic        m_waitrequest;

  vga_fill_ctrl dut (
    .clk           (clk),
    .reset         (reset),
    .s_address     (s_address),
    .s_read        (s_read),
    .s_readdata    (s_readdata),
    .s_write       (s_write),
    .s_writedata   (s_writedata),
    .m_write       (m_write),
    .m_writedata   (m_writedata),
    .m_waitrequest (m_waitrequest)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          vec_cnt = 0;
  int          err_cnt = 0;
  logic [31:0] exp_q[$];
  bit          mon_en = 1'b0;
  bit          timing_chk = 1'b0;
  bit          prev_stall = 1'b0;
  logic [31:0] prev_data = '0;
  int unsigned start_cyc = 0;
  int unsigned beat_idx = 0;

  task automatic checkOutput(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)",
               tag, got, exp, cyc);
    end
  endtask

  // Pixel list of the clipped, normalised rectangle in row-major order.
  task automatic buildExpected(input int x0, input int y0, input int x1,
                               input int y1, input int col);
    int xl, xh, yl, yh;
    exp_q.delete();
    xl = (x0 < x1) ? x0 : x1;
    xh = (x0 < x1) ? x1 : x0;
    yl = (y0 < y1) ? y0 : y1;
    yh = (y0 < y1) ? y1 : y0;
    if (xh > H - 1) xh = H - 1;
    if (yh > V - 1) yh = V - 1;
    if (xl < H && yl < V)
      for (int y = yl; y <= yh; y++)
        for (int x = xl; x <= xh; x++)
          exp_q.push_back(32'(y * 16777216 + x * 65536 + col));
  endtask

  // Beat monitor: scoreboard on every accepted beat, hold check on stalls.
  always @(negedge clk) begin
    if (mon_en) begin
      if (prev_stall) begin
        checkOutput("hold_data", m_writedata, prev_data);
        checkOutput("hold_write", 32'(m_write), 32'd1);
      end
      if (m_write && !m_waitrequest) begin
        checkOutput("beat_expected", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) checkOutput("beat_data", m_writedata, exp_q.pop_front());
        if (timing_chk) checkOutput("beat_cycle", cyc, start_cyc + 2 + beat_idx);
        beat_idx++;
      end
      prev_stall = m_write && m_waitrequest;
      prev_data  = m_writedata;
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic regWrite(input logic [3:0] addr, input logic [31:0] data);
    s_address   = addr;
    s_writedata = data;
    s_write     = 1'b1;
    tick();
    s_write     = 1'b0;
    s_writedata = '0;
  endtask

  task automatic regRead(input logic [3:0] addr, output logic [31:0] data);
    s_address = addr;
    s_read    = 1'b1;
    tick();
    s_read    = 1'b0;
    data      = s_readdata;
  endtask

  task automatic checkAllRegsZero(input string tag);
    logic [31:0] rd;
    for (int a = 0; a < 8; a++) begin
      regRead(4'(a), rd);
      checkOutput($sformatf("%s_reg%0d", tag, a), rd, 32'd0);
    end
  endtask

  // mode 0: no stall, 1: random stall, 2: random stall plus writes while busy.
  task automatic applyStimulus(input int x0, input int y0, input int x1,
                               input int y1, input int col, input int mode);
    logic [31:0] st, rd;
    int          n;
    bit          finished;
    int unsigned issue, done_issue;
    buildExpected(x0, y0, x1, y1, col);
    n = exp_q.size();
    m_waitrequest = 1'b0;
    regWrite(4'd1, 32'(x0));
    regWrite(4'd2, 32'(y0));
    regWrite(4'd3, 32'(x1));
    regWrite(4'd4, 32'(y1));
    regWrite(4'd5, 32'(col));
    beat_idx   = 0;
    timing_chk = (mode == 0);
    mon_en     = 1'b1;
    start_cyc  = cyc;
    regWrite(4'd0, 32'd1);
    finished   = 1'b0;
    done_issue = 0;
    for (int i = 0; i < 400 && !finished; i++) begin
      if (mode != 0) m_waitrequest = 1'($urandom_range(0, 1));
      issue = cyc;
      regRead(4'd0, st);
      if (i == 0) checkOutput("busy_after_start", {31'd0, st[0]}, 32'd1);
      if (i == 0 && mode == 2) begin
        m_waitrequest = 1'b1;
        regWrite(4'd1, 32'd0);
        regWrite(4'd5, 32'hFF);
        regWrite(4'd0, 32'd1);
      end
      if (st[1:0] == 2'b10) begin
        finished   = 1'b1;
        done_issue = issue;
      end
    end
    m_waitrequest = 1'b0;
    checkOutput("op_finished", 32'(finished), 32'd1);
    if (n == 0) checkOutput("empty_done_latency", 32'(done_issue - start_cyc <= 3), 32'd1);
    tick();
    checkOutput("beats_missing", 32'(exp_q.size()), 32'd0);
    checkOutput("m_write_after_done", 32'(m_write), 32'd0);
    regRead(4'd6, rd);
    checkOutput("count", rd, 32'(n));
    if (mode == 2) begin
      regRead(4'd1, rd);
      checkOutput("x0_kept", rd, 32'(x0 & 255));
      regRead(4'd5, rd);
      checkOutput("colour_kept", rd, 32'(col & 255));
    end
    mon_en = 1'b0;
  endtask

  // Two beats flow, the third is stalled when abort arrives, then released.
  task automatic abortTest;
    logic [31:0] rd;
    int          col;
    col = int'($urandom_range(0, 255));
    buildExpected(5, 3, 9, 3, col);
    while (exp_q.size() > 3) void'(exp_q.pop_back());
    m_waitrequest = 1'b0;
    regWrite(4'd1, 32'd5);
    regWrite(4'd2, 32'd3);
    regWrite(4'd3, 32'd9);
    regWrite(4'd4, 32'd3);
    regWrite(4'd5, 32'(col));
    beat_idx   = 0;
    timing_chk = 1'b0;
    mon_en     = 1'b1;
    start_cyc  = cyc;
    regWrite(4'd0, 32'd1);
    tick();
    tick();
    tick();
    m_waitrequest = 1'b1;
    regWrite(4'd0, 32'd2);
    tick();
    m_waitrequest = 1'b0;
    tick();
    tick();
    tick();
    checkOutput("abort_m_write", 32'(m_write), 32'd0);
    checkOutput("abort_beats_missing", 32'(exp_q.size()), 32'd0);
    checkOutput("abort_beat_total", 32'(beat_idx), 32'd3);
    regRead(4'd0, rd);
    checkOutput("abort_status", rd, 32'd0);
    regRead(4'd6, rd);
    checkOutput("abort_count", rd, 32'd3);
    mon_en = 1'b0;
  endtask

  task automatic resetTest;
    mon_en        = 1'b0;
    m_waitrequest = 1'b0;
    regWrite(4'd1, 32'd0);
    regWrite(4'd2, 32'd0);
    regWrite(4'd3, 32'd9);
    regWrite(4'd4, 32'd9);
    regWrite(4'd5, 32'h33);
    regWrite(4'd0, 32'd1);
    tick();
    tick();
    tick();
    checkOutput("pre_reset_drawing", 32'(m_write), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checkOutput("reset_m_write", 32'(m_write), 32'd0);
    checkOutput("reset_m_writedata", m_writedata, 32'd0);
    checkAllRegsZero("after_mid_reset");
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation exceeded its time budget");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int x0, y0, x1, y1, t;
    logic [31:0] rd;
    reset         = 1'b1;
    s_address     = '0;
    s_read        = 1'b0;
    s_write       = 1'b0;
    s_writedata   = '0;
    m_waitrequest = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    checkOutput("reset_m_write", 32'(m_write), 32'd0);
    checkOutput("reset_m_writedata", m_writedata, 32'd0);
    checkOutput("reset_readdata", s_readdata, 32'd0);
    checkAllRegsZero("after_reset");

    regWrite(4'd7, 32'hFFFF_FFFF);
    regRead(4'd7, rd);
    checkOutput("unmapped_read", rd, 32'd0);
    regWrite(4'd0, 32'd3);
    tick();
    regRead(4'd0, rd);
    checkOutput("start_with_abort", rd, 32'd0);

    applyStimulus(10, 20, 11, 21, 8'hA5, 0);
    applyStimulus(11, 21, 10, 20, 8'hA5, 0);
    applyStimulus(158, 118, 200, 127, 8'h3C, 0);
    applyStimulus(170, 5, 170, 9, 8'h11, 0);
    applyStimulus(5, 125, 6, 127, 8'h22, 0);
    applyStimulus(0, 0, 0, 0, 8'hFF, 0);
    applyStimulus(159, 119, 159, 119, 8'h01, 0);
    applyStimulus(20, 30, 22, 30, 8'h5A, 1);
    applyStimulus(40, 50, 41, 51, 8'h77, 2);
    abortTest();

    for (int i = 0; i < 12; i++) begin
      x0 = int'($urandom_range(0, 175));
      x1 = x0 + int'($urandom_range(0, 5));
      y0 = int'($urandom_range(0, 124));
      y1 = y0 + int'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) begin
        t = x0; x0 = x1; x1 = t;
      end
      if ($urandom_range(0, 1) == 1) begin
        t = y0; y0 = y1; y1 = t;
      end
      applyStimulus(x0, y0, x1, y1, int'($urandom_range(0, 255)),
                    int'($urandom_range(0, 1)));
    end

    resetTest();

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
